stm_focus_writer: RTL and testbench



---
 rtl/stm_focus_pkg.sv | 28 ++
 rtl/stm_focus_word_assembler.sv | 46 ++++
 rtl/stm_focus_writer.sv | 160 ++++++++++++++++
 tb/tb_stm_focus_writer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stm_focus_pkg.sv
// Shared types and entry layout for the focus STM writer and reader.
// Latency: none (declarations only).
// Backpressure: not applicable.
package stm_focus_pkg;

    // Writer FSM states.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSEMBLE = 2'd1,
        S_COMMIT   = 2'd2
    } state_t;

    // Focus entry field layout; the reader decodes with the same offsets.
    localparam int X_LSB   = 0;
    localparam int Y_LSB   = 18;
    localparam int Z_LSB   = 36;
    localparam int INT_LSB = 54;
    localparam int FIELD_W = 18;
    localparam int INT_W   = 8;

    localparam int ENTRY_W         = 64;
    localparam int WORDS_PER_ENTRY = 4;
    localparam int WORD_W          = 16;

    // Payload bits actually carried by an entry; the two top bits are always 0.
    localparam int PAYLOAD_W = INT_LSB + INT_W;

endpackage

// File: rtl/stm_focus_word_assembler.sv
// Merges four 16-bit host words into one focus entry and tracks the next expected word.
// Latency: a word is stored on the edge following start/accept.
// Backpressure: none; the controlling FSM decides which words are taken.
import stm_focus_pkg::*;

module stm_focus_word_assembler (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   start,
    input  logic                                   accept,
    input  logic [WORD_W-1:0]                      word_dat,
    output logic [ENTRY_W-1:0]                     entry,
    output logic [$clog2(WORDS_PER_ENTRY)-1:0]     exp_word
);

    // Only the 62 payload bits are stored; word 3 contributes its low 14 bits.
    logic [PAYLOAD_W-1:0] ent_q;

    // Word storage and expected-word counter; start always restarts at word 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ent_q    <= '0;
            exp_word <= '0;
        end else if (start) begin
            ent_q[15:0] <= word_dat;
            exp_word    <= 2'd1;
        end else if (accept) begin
            case (exp_word)
                2'd1:    ent_q[31:16] <= word_dat;
                2'd2:    ent_q[47:32] <= word_dat;
                default: ent_q[PAYLOAD_W-1:48] <= word_dat[PAYLOAD_W-49:0];
            endcase
            exp_word <= exp_word + 2'd1;
        end
    end

    // Repack by field so the reserved top bits are structurally zero.
    always_comb begin
        entry                     = '0;
        entry[X_LSB +: FIELD_W]   = ent_q[X_LSB +: FIELD_W];
        entry[Y_LSB +: FIELD_W]   = ent_q[Y_LSB +: FIELD_W];
        entry[Z_LSB +: FIELD_W]   = ent_q[Z_LSB +: FIELD_W];
        entry[INT_LSB +: INT_W]   = ent_q[INT_LSB +: INT_W];
    end

endmodule

// File: rtl/stm_focus_writer.sv
// Focus STM write front end: assembles host words into entries, writes BRAM, tracks COUNT.
// Latency: BRAM_WE one cycle after the word-3 strobe; back-to-back entries run gap-free.
// Backpressure: none; bad words set sticky ERR. Optional idle timeout: STM_FOCUS_WR_TIMEOUT_EN.
import stm_focus_pkg::*;

module stm_focus_writer #(
    parameter int unsigned FOCUS_NUM_MAX = 8192,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_EN,
    input  logic [17:0] WR_ADDR,
    input  logic [15:0] WR_DATA,
    input  logic        SEGMENT,
    input  logic        CLEAR,
    output logic        BRAM_WE,
    output logic [16:0] BRAM_ADDR,
    output logic [63:0] BRAM_DIN,
    output logic [15:0] COUNT,
    output logic        BUSY,
    output logic        ERR
);

    // COUNT cannot exceed the segment size nor the 16-bit output range.
    localparam int unsigned CNT_CAP = (FOCUS_NUM_MAX > 32'd65535) ? 32'd65535 : FOCUS_NUM_MAX;

    state_t      state, nxt_state;
    logic [15:0] cur_idx;
    logic        cur_seg;
    logic        start, accept, err_set, timeout_hit;
    logic [1:0]  exp_word;
    logic [ENTRY_W-1:0] entry;

    logic [15:0] wr_idx;
    logic [1:0]  wr_word;
    logic        idx_ok;
    logic [16:0] idx_inc;
    logic [15:0] cnt_cand;

    assign wr_idx  = WR_ADDR[17:2];
    assign wr_word = WR_ADDR[1:0];
    assign idx_ok  = ({16'd0, wr_idx} < FOCUS_NUM_MAX);

    stm_focus_word_assembler u_asm (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .accept   (accept),
        .word_dat (WR_DATA),
        .entry    (entry),
        .exp_word (exp_word)
    );

`ifdef STM_FOCUS_WR_TIMEOUT_EN
    logic [15:0] idle_cnt;

    assign timeout_hit = (state == S_ASSEMBLE) && !WR_EN &&
                         ({16'd0, idle_cnt} == TIMEOUT - 32'd1);

    // Idle-cycle counter; any host strobe or leaving ASSEMBLE restarts it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            idle_cnt <= '0;
        else if (state != S_ASSEMBLE || WR_EN)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 16'd1;
    end
`else
    assign timeout_hit = 1'b0;
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    // Next-state and strobe decode; COMMIT also accepts a new word 0 like IDLE.
    always_comb begin
        nxt_state = state;
        start     = 1'b0;
        accept    = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_ASSEMBLE: begin
                if (WR_EN) begin
                    if (wr_idx == cur_idx && wr_word == exp_word) begin
                        accept = 1'b1;
                        if (exp_word == 2'd3)
                            nxt_state = S_COMMIT;
                    end else if (wr_word == 2'd0) begin
                        // New entry interrupts the old one; out-of-range index leaves it intact.
                        err_set = 1'b1;
                        start   = idx_ok;
                    end else begin
                        err_set   = 1'b1;
                        nxt_state = S_IDLE;
                    end
                end else if (timeout_hit) begin
                    err_set   = 1'b1;
                    nxt_state = S_IDLE;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                if (WR_EN) begin
                    if (wr_word == 2'd0 && idx_ok) begin
                        start     = 1'b1;
                        nxt_state = S_ASSEMBLE;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
        endcase
    end

    // State register plus the index/segment latched at word 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            cur_idx <= '0;
            cur_seg <= 1'b0;
        end else begin
            state <= nxt_state;
            if (start) begin
                cur_idx <= wr_idx;
                cur_seg <= SEGMENT;
            end
        end
    end

    assign idx_inc  = {1'b0, cur_idx} + 17'd1;
    assign cnt_cand = ({15'd0, idx_inc} > CNT_CAP) ? 16'(CNT_CAP) : idx_inc[15:0];

    // COUNT tracks the high-water mark; a commit overrides a coincident CLEAR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            COUNT <= '0;
        else if (state == S_COMMIT) begin
            if (CLEAR || cnt_cand > COUNT)
                COUNT <= cnt_cand;
        end else if (CLEAR)
            COUNT <= '0;
    end

    // Sticky error; a fresh error in the CLEAR cycle survives the clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            ERR <= 1'b0;
        else if (err_set)
            ERR <= 1'b1;
        else if (CLEAR)
            ERR <= 1'b0;
    end

    assign BRAM_WE   = (state == S_COMMIT);
    assign BRAM_ADDR = {cur_seg, cur_idx};
    assign BRAM_DIN  = entry;
    assign BUSY      = (state == S_ASSEMBLE);

endmodule

// File: tb/tb_stm_focus_writer.sv
// Randomised and directed bench for stm_focus_writer against an entry-level reference model.
// Latency: every cycle's outputs are compared #1 after the active edge.
// Backpressure: not applicable; the host strobes whenever it likes.
module tb_stm_focus_writer;

    localparam int NMAX = 8192;
    localparam int CAP  = 8192;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WR_EN;
    logic [17:0] WR_ADDR;
    logic [15:0] WR_DATA;
    logic        SEGMENT;
    logic        CLEAR;
    logic        BRAM_WE;
    logic [16:0] BRAM_ADDR;
    logic [63:0] BRAM_DIN;
    logic [15:0] COUNT;
    logic        BUSY;
    logic        ERR;

    stm_focus_writer #(.FOCUS_NUM_MAX(NMAX), .TIMEOUT(255)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WR_EN     (WR_EN),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .SEGMENT   (SEGMENT),
        .CLEAR     (CLEAR),
        .BRAM_WE   (BRAM_WE),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_DIN  (BRAM_DIN),
        .COUNT     (COUNT),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int we_cyc[$];

    // Reference model: an open partial entry, its words, and a pending write.
    bit          m_open;
    int          m_idx;
    bit          m_seg;
    int          m_next;
    logic [15:0] m_words [4];
    bit          m_commit;
    int          m_c_idx;
    logic [16:0] m_c_addr;
    logic [63:0] m_c_din;
    int          m_count;
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_open   = 0;
        m_idx    = 0;
        m_seg    = 0;
        m_next   = 0;
        m_commit = 0;
        m_c_idx  = 0;
        m_c_addr = '0;
        m_c_din  = '0;
        m_count  = 0;
        m_err    = 0;
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input bit en, input logic [17:0] addr, input logic [15:0] dat,
                              input bit seg, input bit clr);
        int idx, w, cand;
        bit errev, commit_nxt;
        idx        = int'(addr[17:2]);
        w          = int'(addr[1:0]);
        errev      = 0;
        commit_nxt = 0;
        if (m_commit) begin
            cand = m_c_idx + 1;
            if (cand > CAP) cand = CAP;
            if (clr || cand > m_count) m_count = cand;
        end else if (clr) begin
            m_count = 0;
        end
        if (en) begin
            if (!m_open) begin
                if (w == 0 && idx < NMAX) begin
                    m_open = 1; m_idx = idx; m_seg = seg; m_words[0] = dat; m_next = 1;
                end else begin
                    errev = 1;
                end
            end else if (idx == m_idx && w == m_next) begin
                m_words[w] = dat;
                m_next++;
                if (m_next == 4) begin
                    commit_nxt = 1;
                    m_open     = 0;
                    m_c_idx    = m_idx;
                    m_c_addr   = {m_seg, 16'(m_idx)};
                    m_c_din    = {2'b00, m_words[3][13:0], m_words[2], m_words[1], m_words[0]};
                end
            end else if (w == 0) begin
                errev = 1;
                if (idx < NMAX) begin
                    m_idx = idx; m_seg = seg; m_words[0] = dat; m_next = 1;
                end
            end else begin
                errev  = 1;
                m_open = 0;
            end
        end
        m_commit = commit_nxt;
        if (errev) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic check_outputs();
        chk("bram_we", 64'(BRAM_WE), 64'(m_commit));
        if (m_commit) begin
            chk("bram_addr", 64'(BRAM_ADDR), 64'(m_c_addr));
            chk("bram_din", BRAM_DIN, m_c_din);
        end
        chk("count", 64'(COUNT), 64'(m_count));
        chk("busy", 64'(BUSY), 64'(m_open));
        chk("err", 64'(ERR), 64'(m_err));
    endtask

    task automatic drive(input bit en, input logic [17:0] addr, input logic [15:0] dat,
                         input bit seg, input bit clr);
        WR_EN   = en;
        WR_ADDR = addr;
        WR_DATA = dat;
        SEGMENT = seg;
        CLEAR   = clr;
        model_step(en, addr, dat, seg, clr);
        @(posedge CLK);
        #1;
        cyc++;
        check_outputs();
        if (BRAM_WE) we_cyc.push_back(cyc);
    endtask

    task automatic wr(input int idx, input int k, input logic [15:0] dat, input bit seg, input bit clr);
        drive(1'b1, {idx[15:0], k[1:0]}, dat, seg, clr);
    endtask

    task automatic idle(input int n, input bit clr);
        for (int i = 0; i < n; i++)
            drive(1'b0, 18'($urandom), 16'($urandom), 1'($urandom), clr);
    endtask

    task automatic entry(input int idx, input bit seg);
        for (int k = 0; k < 4; k++)
            wr(idx, k, 16'($urandom), seg, 1'b0);
    endtask

    initial begin
        RST = 1'b1; WR_EN = 0; WR_ADDR = '0; WR_DATA = '0; SEGMENT = 0; CLEAR = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_we", 64'(BRAM_WE), 64'd0);
        chk("rst_addr", 64'(BRAM_ADDR), 64'd0);
        chk("rst_din", BRAM_DIN, 64'd0);
        chk("rst_count", 64'(COUNT), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        RST = 1'b0;

        // Full entry to index 5 in segment 1; SEGMENT toggles after word 0 are ignored.
        wr(5, 0, 16'h1111, 1'b1, 1'b0);
        wr(5, 1, 16'h2222, 1'b0, 1'b0);
        wr(5, 2, 16'h3333, 1'b0, 1'b0);
        wr(5, 3, 16'hFFFF, 1'b0, 1'b0);
        chk("t1_we", 64'(BRAM_WE), 64'd1);
        chk("t1_addr", 64'(BRAM_ADDR), 64'h10005);
        chk("t1_din", BRAM_DIN, 64'h3FFF333322221111);
        idle(1, 1'b0);
        chk("t1_count", 64'(COUNT), 64'd6);
        chk("t1_err", 64'(ERR), 64'd0);
        chk("t1_we_once", 64'(we_cyc.size()), 64'd1);

        // Back-to-back entries 0 and 1 after a CLEAR.
        idle(1, 1'b1);
        we_cyc.delete();
        entry(0, 1'b0);
        entry(1, 1'b0);
        idle(1, 1'b0);
        chk("b2b_pulses", 64'(we_cyc.size()), 64'd2);
        if (we_cyc.size() == 2)
            chk("b2b_spacing", 64'(we_cyc[1] - we_cyc[0]), 64'd4);
        chk("b2b_count", 64'(COUNT), 64'd2);

        // Word 0 then word 2 of index 3: protocol error, then a good entry still commits.
        we_cyc.delete();
        wr(3, 0, 16'hABCD, 1'b0, 1'b0);
        wr(3, 2, 16'h1234, 1'b0, 1'b0);
        chk("skip_err", 64'(ERR), 64'd1);
        chk("skip_busy", 64'(BUSY), 64'd0);
        entry(4, 1'b1);
        idle(1, 1'b0);
        chk("skip_writes", 64'(we_cyc.size()), 64'd1);

        // Word 0 at index FOCUS_NUM_MAX is rejected.
        idle(1, 1'b1);
        we_cyc.delete();
        wr(NMAX, 0, 16'h5555, 1'b0, 1'b0);
        chk("oor_err", 64'(ERR), 64'd1);
        chk("oor_busy", 64'(BUSY), 64'd0);
        idle(2, 1'b0);
        chk("oor_nowrite", 64'(we_cyc.size()), 64'd0);

        // CLEAR coincident with the commit of index 9 (COUNT was 21).
        entry(20, 1'b0);
        idle(1, 1'b0);
        entry(9, 1'b0);
        idle(1, 1'b1);
        chk("clr_commit_count", 64'(COUNT), 64'd10);
        chk("clr_commit_err", 64'(ERR), 64'd0);

        // Last legal index saturates COUNT at FOCUS_NUM_MAX.
        entry(NMAX - 1, 1'b1);
        idle(1, 1'b0);
        chk("max_count", 64'(COUNT), 64'(NMAX));

        // Reset after word 2: nothing written, everything zero.
        we_cyc.delete();
        wr(7, 0, 16'h0707, 1'b1, 1'b0);
        wr(7, 1, 16'h1717, 1'b1, 1'b0);
        wr(7, 2, 16'h2727, 1'b1, 1'b0);
        WR_EN = 1'b0;
        RST   = 1'b1;
        #1;
        chk("mid_rst_we", 64'(BRAM_WE), 64'd0);
        chk("mid_rst_addr", 64'(BRAM_ADDR), 64'd0);
        chk("mid_rst_din", BRAM_DIN, 64'd0);
        chk("mid_rst_count", 64'(COUNT), 64'd0);
        chk("mid_rst_busy", 64'(BUSY), 64'd0);
        chk("mid_rst_err", 64'(ERR), 64'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(3, 1'b0);
        chk("mid_rst_nowrite", 64'(we_cyc.size()), 64'd0);

        // Random streams: mostly legal entries, with corrupted words, gaps, CLEARs, bad indices.
        for (int n = 0; n < 150; n++) begin
            int idx;
            bit seg;
            idx = ($urandom_range(0, 9) == 0) ? NMAX - 2 + int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 40));
            seg = 1'($urandom);
            for (int k = 0; k < 4; k++) begin
                int w, i2, r;
                w  = k;
                i2 = idx;
                r  = int'($urandom_range(0, 29));
                if (r == 0) w = int'($urandom_range(0, 3));
                else if (r == 1) i2 = idx ^ 1;
                wr(i2, w, 16'($urandom), (k == 0) ? seg : 1'($urandom),
                   $urandom_range(0, 15) == 0);
                if ($urandom_range(0, 2) == 0)
                    idle(int'($urandom_range(1, 3)), $urandom_range(0, 7) == 0);
            end
        end
        idle(2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
